// File: rtl/prog_counter.sv
// prog_counter: a programmable up/down counter with a prescaled tick.
//   It has an enable, a synchronous load (clamped to MAX), a one-shot halt mode,
//   a registered terminal-count pulse and a combinational compare-match flag.
// Ports:
//   CLK        rising-edge clock
//   RST_N      synchronous active-low reset
//   EN         enables the prescaler; when low, the prescaler and counter freeze
//   PRESCALE   one tick every PRESCALE+1 enabled cycles
//   DIR        1 = count up, 0 = count down
//   ONESHOT    1 = halt at terminal, 0 = wrap
//   LOAD       synchronous load strobe (beats a coincident tick)
//   LOAD_VAL   value to load, clamped to MAX
//   CMP_VAL    compare value for CMP_MATCH
//   counter    registered count
//   TC         registered one-cycle terminal-count pulse
//   CMP_MATCH  counter == CMP_VAL (combinational)
//   RUNNING    1 in RUN state, 0 in HALT state
module prog_counter #(
  parameter int WIDTH      = 4,
  parameter int MAX        = 2**WIDTH-1,
  parameter int PRESCALE_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  DIR,
  input  logic                  ONESHOT,
  input  logic                  LOAD,
  input  logic [WIDTH-1:0]      LOAD_VAL,
  input  logic [WIDTH-1:0]      CMP_VAL,
  output logic [WIDTH-1:0]      counter,
  output logic                  TC,
  output logic                  CMP_MATCH,
  output logic                  RUNNING
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tc_q, tc_d;
  logic                  tick;
  logic [WIDTH-1:0]      load_cl;

  // The clamp is only built when MAX leaves some codes unused.
  // A full-range MAX would otherwise give a constant comparison.
  generate
    if (MAX < 2**WIDTH-1) begin : g_clamp
      assign load_cl = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
    end else begin : g_noclamp
      assign load_cl = LOAD_VAL;
    end
  endgenerate

  // The >= test makes a lowered PRESCALE take effect on the next enabled cycle.
  // It does not wait for the prescaler to wrap around.
  assign tick = EN && (pre_q >= PRESCALE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    pre_d   = pre_q;
    if (EN) pre_d = tick ? '0 : pre_q + PRESCALE_W'(1);

    if (LOAD) begin
      // A load overrides any coincident tick.
      // It also restarts the prescale phase.
      cnt_d   = load_cl;
      pre_d   = '0;
      state_d = ST_RUN;
    end else if (tick && state_q == ST_RUN) begin
      if (DIR) begin
        if (cnt_q == MAX_V) begin
          tc_d = 1'b1;
          if (ONESHOT) state_d = ST_HALT;
          else         cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d = 1'b1;
          if (ONESHOT) state_d = ST_HALT;
          else         cnt_d   = MAX_V;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign counter   = cnt_q;
  assign TC        = tc_q;
  assign RUNNING   = (state_q == ST_RUN);
  assign CMP_MATCH = (cnt_q == CMP_VAL);

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  logic       CLK = 1'b0;
  logic       RST_N, EN, DIR, ONESHOT, LOAD;
  logic [3:0] PRESCALE, LOAD_VAL, CMP_VAL;
  logic [3:0] counter, counter9;
  logic       TC, CMP_MATCH, RUNNING;
  logic       TC9, CMP_MATCH9, RUNNING9;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  prog_counter #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PRESCALE(PRESCALE), .DIR(DIR),
    .ONESHOT(ONESHOT), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .CMP_VAL(CMP_VAL),
    .counter(counter), .TC(TC), .CMP_MATCH(CMP_MATCH), .RUNNING(RUNNING)
  );

  prog_counter #(.WIDTH(4), .MAX(9), .PRESCALE_W(4)) dut9 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PRESCALE(PRESCALE), .DIR(DIR),
    .ONESHOT(ONESHOT), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .CMP_VAL(CMP_VAL),
    .counter(counter9), .TC(TC9), .CMP_MATCH(CMP_MATCH9), .RUNNING(RUNNING9)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle past it before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b1; PRESCALE = 4'd0; DIR = 1'b1; ONESHOT = 1'b0;
    LOAD = 1'b0; LOAD_VAL = 4'd0; CMP_VAL = 4'd0;

    // reset, then free-run up on both builds
    step();
    chk("rst_cnt", counter, 0);
    chk("rst_tc", TC, 0);
    chk("rst_run", RUNNING, 1);
    chk("rst_cnt9", counter9, 0);
    RST_N = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("up_cnt", counter, i % 16);
      chk("up_tc", TC, (i % 16) == 0);
      chk("m9_cnt", counter9, i % 10);
      chk("m9_tc", TC9, (i % 10) == 0);
    end

    // load 3, count down through the wrap, and watch the compare flag at 1
    DIR = 1'b0; CMP_VAL = 4'd1; LOAD = 1'b1; LOAD_VAL = 4'd3;
    step();
    LOAD = 1'b0;
    chk("dn_load", counter, 3);
    chk("dn_cmp3", CMP_MATCH, 0);
    begin
      int exp_c[5]  = '{2, 1, 0, 15, 14};
      int exp_tc[5] = '{0, 0, 0, 1, 0};
      for (int i = 0; i < 5; i++) begin
        step();
        chk("dn_cnt", counter, exp_c[i]);
        chk("dn_tc", TC, exp_tc[i]);
        chk("dn_cmp", CMP_MATCH, exp_c[i] == 1);
      end
    end

    // prescale 2, freeze with EN low, then lower PRESCALE mid-count
    DIR = 1'b1; PRESCALE = 4'd2; LOAD = 1'b1; LOAD_VAL = 4'd0;
    step();
    LOAD = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("ps_cnt", counter, e / 3);
    end
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ps_frz", counter, 1);
    end
    EN = 1'b1;
    for (int e = 5; e <= 7; e++) begin
      step();
      chk("ps_res", counter, e / 3);
    end
    // prescaler phase is now 1; PRESCALE=0 must tick on the very next edge
    PRESCALE = 4'd0;
    step();
    chk("ps_lower", counter, 3);

    // one-shot up from 13
    ONESHOT = 1'b1; LOAD = 1'b1; LOAD_VAL = 4'd13;
    step();
    LOAD = 1'b0;
    chk("os_load", counter, 13);
    chk("os_clamp9", counter9, 9);
    step();
    chk("os_14", counter, 14);
    chk("os9_tc", TC9, 1);
    chk("os9_halt", RUNNING9, 0);
    step();
    chk("os_15", counter, 15);
    step();
    chk("os_term", counter, 15);
    chk("os_tc", TC, 1);
    chk("os_halt", RUNNING, 0);
    for (int i = 0; i < 21; i++) begin
      step();
      if (i == 0 || i == 20) begin
        chk("os_hold", counter, 15);
        chk("os_tc0", TC, 0);
        chk("os_halt2", RUNNING, 0);
      end
    end
    LOAD = 1'b1; LOAD_VAL = 4'd12;
    step();
    LOAD = 1'b0;
    chk("os_reload", counter, 12);
    chk("os_rerun", RUNNING, 1);
    chk("ld9_clamp", counter9, 9);
    chk("ld9_rerun", RUNNING9, 1);
    ONESHOT = 1'b0;

    // reset mid-count with LOAD asserted; LOAD must be ignored
    LOAD = 1'b1; LOAD_VAL = 4'd9;
    step();
    chk("pre_rst9", counter, 9);
    RST_N = 1'b0; LOAD_VAL = 4'd5;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mrst_cnt", counter, 0);
      chk("mrst_tc", TC, 0);
      chk("mrst_run", RUNNING, 1);
    end
    RST_N = 1'b1; LOAD = 1'b0;
    step();
    chk("mrst_1", counter, 1);
    step();
    chk("mrst_2", counter, 2);

    // load beats a terminal tick: no TC, and the count continues from the load value
    LOAD = 1'b1; LOAD_VAL = 4'd15;
    step();
    chk("lt_15", counter, 15);
    LOAD_VAL = 4'd6;
    step();
    LOAD = 1'b0;
    chk("lt_cnt", counter, 6);
    chk("lt_tc", TC, 0);
    step();
    chk("lt_next", counter, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
